// File: rtl/t03_wb_arb_pkg.sv
// t03_wb_arb_pkg: shared states, requester ids and constants for the Wishbone arbiter
package t03_wb_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBAD0_BAD0;
endpackage

// File: rtl/t03_rr_pick2.sv
// t03_rr_pick2: combinational two-way round-robin picker favouring the requester not granted last
module t03_rr_pick2
    import t03_wb_arb_pkg::*;
(
    input  logic    a_req,
    input  logic    b_req,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant_id
);
    assign grant_valid = a_req | b_req;
    assign grant_id    = (a_req && b_req) ? ((last_grant == REQ_A) ? REQ_B : REQ_A)
                                          : (b_req ? REQ_B : REQ_A);
endmodule

// File: rtl/t03_wb_arbiter.sv
// t03_wb_arbiter: round-robin sequencer for two requesters in front of a Wishbone manager, with a hung-bus watchdog
module t03_wb_arbiter
    import t03_wb_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_wen,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_sel,
    output logic [31:0] a_rdata,
    output logic        a_ack,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_wen,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_sel,
    output logic [31:0] b_rdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_sel,
    output logic        m_wen,
    output logic        m_ren,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        busy,
    output logic        owner
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    req_id_t       r_last;
    req_id_t       r_owner;
    logic          r_cmd_wen;
    logic [31:0]   r_cmd_addr;
    logic [31:0]   r_cmd_wdata;
    logic [3:0]    r_cmd_sel;
    logic [TW-1:0] r_timer;
    logic [31:0]   r_a_rdata;
    logic [31:0]   r_b_rdata;
    logic          r_err;

    logic          w_grant_valid;
    req_id_t       w_grant_id;
    logic          w_pick_b;
    logic          w_fin_ack;
    logic          w_fin_to;
    logic          w_cap;
    logic [31:0]   w_cap_data;

    t03_rr_pick2 u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_grant  (r_last),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    assign w_pick_b   = (w_grant_id == REQ_B);
    // ack beats the watchdog when both land in the same WAIT cycle
    assign w_fin_ack  = (r_state == WAIT) && m_ack;
    assign w_fin_to   = (r_state == WAIT) && !m_ack && (TIMEOUT_CYCLES != 0) && (r_timer == T_LAST);
    assign w_cap      = (w_fin_ack && !r_cmd_wen) || w_fin_to;
    assign w_cap_data = w_fin_ack ? m_rdata : ERR_DATA;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= REQ_B;
            r_owner     <= REQ_A;
            r_cmd_wen   <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_sel   <= '0;
            r_timer     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_grant_valid) begin
                    r_state     <= ISSUE;
                    r_owner     <= w_grant_id;
                    r_cmd_wen   <= w_pick_b ? b_wen   : a_wen;
                    r_cmd_addr  <= w_pick_b ? b_addr  : a_addr;
                    r_cmd_wdata <= w_pick_b ? b_wdata : a_wdata;
                    r_cmd_sel   <= w_pick_b ? b_sel   : a_sel;
                end
                ISSUE: begin
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_timer != '1) r_timer <= r_timer + 1'b1;
                    if (w_fin_ack || w_fin_to) begin
                        r_err   <= w_fin_to;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else if (w_cap) begin
            if (r_owner == REQ_A) r_a_rdata <= w_cap_data;
            if (r_owner == REQ_B) r_b_rdata <= w_cap_data;
        end
    end

    assign m_addr  = r_cmd_addr;
    assign m_wdata = r_cmd_wdata;
    assign m_sel   = r_cmd_sel;
    assign m_wen   = (r_state == ISSUE) && r_cmd_wen;
    assign m_ren   = (r_state == ISSUE) && !r_cmd_wen;
    assign busy    = (r_state != IDLE);
    assign owner   = r_owner;
    assign a_ack   = (r_state == DONE) && (r_owner == REQ_A);
    assign b_ack   = (r_state == DONE) && (r_owner == REQ_B);
    assign a_err   = a_ack && r_err;
    assign b_err   = b_ack && r_err;
    assign a_rdata = r_a_rdata;
    assign b_rdata = r_b_rdata;
endmodule

// File: tb/tb_t03_wb_arbiter.sv
// tb_t03_wb_arbiter: randomized transactions against a transaction-level arbiter and manager model
module tb_t03_wb_arbiter;
    localparam int T = 8;
    localparam logic [31:0] ERRD = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_wen = 1'b0, b_req = 1'b0, b_wen = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic [3:0]  a_sel = '0, b_sel = '0;
    logic [31:0] a_rdata, b_rdata, m_addr, m_wdata;
    logic        a_ack, a_err, b_ack, b_err, m_wen, m_ren, busy, owner;
    logic [3:0]  m_sel;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_ack_cyc = -10;
    int          last = 1;
    logic        pend [2];
    logic        wen_q [2];
    logic [31:0] addr_q [2];
    logic [31:0] wdata_q [2];
    logic [3:0]  sel_q [2];
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    t03_wb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata), .a_sel(a_sel),
        .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata), .b_sel(b_sel),
        .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel), .m_wen(m_wen), .m_ren(m_ren),
        .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy), .owner(owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive();
        a_req = pend[0]; a_wen = wen_q[0]; a_addr = addr_q[0]; a_wdata = wdata_q[0]; a_sel = sel_q[0];
        b_req = pend[1]; b_wen = wen_q[1]; b_addr = addr_q[1]; b_wdata = wdata_q[1]; b_sel = sel_q[1];
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; wen_q[i] = 1'b0; addr_q[i] = '0; wdata_q[i] = '0; sel_q[i] = '0; exp_rd[i] = '0;
        end
        last = 1;
        drive();
    endtask

    task automatic new_req(input int id, input logic w, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] s);
        pend[id] = 1'b1; wen_q[id] = w; addr_q[id] = ad; wdata_q[id] = wd; sel_q[id] = s;
        drive();
    endtask

    task automatic new_rand(input int id);
        new_req(id, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)));
    endtask

    // One arbitration + bus transaction; d is the manager's ack delay after the strobe (d > T: never acks)
    task automatic run_txn(input int d, input logic [31:0] rd, output int win);
        int n;
        logic got;
        logic to;
        win = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
        n = 0;
        do begin
            tick(); n++;
            if (!(m_wen | m_ren)) check("idle_ack", {a_ack, b_ack}, 0);
        end while (!(m_wen | m_ren) && n < 6);
        check("strobe_lat", n, (cyc - n == last_ack_cyc) ? 2 : 1);
        check("m_wen", m_wen, wen_q[win]);
        check("m_ren", m_ren, !wen_q[win]);
        check("m_addr", m_addr, addr_q[win]);
        check("m_wdata", m_wdata, wdata_q[win]);
        check("m_sel", m_sel, sel_q[win]);
        check("owner", owner, win);
        check("busy", busy, 1);
        n = 0;
        got = 1'b0;
        while (!got && n < T + 4) begin
            tick(); n++;
            if (a_ack | b_ack) got = 1'b1;
            else check("stray_strobe", {m_wen, m_ren, busy}, 1);
            m_ack = (n == d);
            m_rdata = (n == d) ? rd : $urandom;
        end
        m_ack = 1'b0;
        to = (d > T);
        if (to) exp_rd[win] = ERRD;
        else if (!wen_q[win]) exp_rd[win] = rd;
        check("ack_cyc", n, to ? T + 1 : d + 1);
        check("a_ack", a_ack, win == 0);
        check("b_ack", b_ack, win == 1);
        check("err", (win == 1) ? b_err : a_err, to);
        check("other_err", (win == 1) ? a_err : b_err, 0);
        check("a_rdata", a_rdata, exp_rd[0]);
        check("b_rdata", b_rdata, exp_rd[1]);
        pend[win] = 1'b0;
        drive();
        last = win;
        last_ack_cyc = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w, n, k;
        reset_model();
        tick(); tick();
        #1;
        check("rst_ctl", {busy, m_wen, m_ren, a_ack, a_err, b_ack, b_err, owner}, 0);
        check("rst_maddr", m_addr, 0);
        check("rst_mwdata", m_wdata, 0);
        check("rst_msel", m_sel, 0);
        check("rst_ardata", a_rdata, 0);
        check("rst_brdata", b_rdata, 0);
        rst = 1'b0;
        tick();
        new_rand(0); new_rand(1);
        for (int i = 0; i < 6; i++) begin
            run_txn(2, $urandom, w);
            check("rr_order", w, i % 2);
            if (i < 4) new_rand(w);
        end
        tick(); tick();
        new_req(0, 1'b0, 32'h3300_0010, $urandom, 4'hF);
        run_txn(4, 32'h1234_5678, w);
        tick();
        new_req(1, 1'b1, 32'h4000_0020, 32'hCAFE_F00D, 4'b0011);
        run_txn(3, $urandom, w);
        tick();
        new_req(0, 1'b0, $urandom, $urandom, 4'hF);
        run_txn(100, $urandom, w);
        new_req(1, 1'b0, $urandom, $urandom, 4'hF);
        run_txn(2, $urandom, w);
        tick();
        new_req(0, 1'b0, $urandom, $urandom, 4'hF);
        run_txn(T, 32'h5555_AAAA, w);
        for (int i = 0; i < 30; i++) begin
            if (!pend[0] && !pend[1]) begin
                repeat ($urandom_range(0, 2)) tick();
                k = $urandom_range(1, 3);
                if (k[0]) new_rand(0);
                if (k[1]) new_rand(1);
            end else if ($urandom_range(0, 1) == 1) begin
                new_rand(pend[0] ? 1 : 0);
            end
            run_txn($urandom_range(1, T + 2), $urandom, w);
        end
        if (pend[0] || pend[1]) run_txn(2, $urandom, w);
        tick();
        new_req(0, 1'b0, $urandom, $urandom, 4'hF);
        n = 0;
        do begin tick(); n++; end while (!m_ren && n < 6);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("amid_ctl", {busy, m_wen, m_ren, a_ack, a_err, b_ack, b_err, owner}, 0);
        check("amid_maddr", m_addr, 0);
        check("amid_ardata", a_rdata, 0);
        check("amid_brdata", b_rdata, 0);
        reset_model();
        repeat (3) begin tick(); check("rst_hold", {busy, a_ack, b_ack}, 0); end
        rst = 1'b0;
        repeat (T + 3) begin tick(); check("post_rst_quiet", {busy, a_ack, b_ack, m_wen, m_ren}, 0); end
        new_rand(0); new_rand(1);
        run_txn(2, $urandom, w);
        check("first_after_rst", w, 0);
        run_txn(2, $urandom, w);
        check("second_after_rst", w, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
